// File: rtl/memory_bus_bram_slave_if.sv
// MemoryBus request/response channel between ray-memory masters and a memory slave.
// Masters drive ms* (plus smTaken); the slave drives msTaken and sm*.
interface memory_bus_bram_slave_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 24,
    parameter int ID_WIDTH      = 4
);
    logic                     msValid;
    logic                     msWrite;
    logic [ID_WIDTH-1:0]      msID;
    logic [ADDRESS_WIDTH-1:0] msAddress;
    logic [DATA_WIDTH-1:0]    msData;
    logic                     msTaken;
    logic                     smValid;
    logic [ID_WIDTH-1:0]      smID;
    logic [DATA_WIDTH-1:0]    smData;
    logic                     smTaken;

    modport master (
        output msValid, msWrite, msID, msAddress, msData, smTaken,
        input  msTaken, smValid, smID, smData
    );

    modport slave (
        input  msValid, msWrite, msID, msAddress, msData, smTaken,
        output msTaken, smValid, smID, smData
    );
endinterface

// File: rtl/memory_bus_bram_slave.sv
// MemoryBus slave in front of a single-port synchronous BRAM with a credit-protected response FIFO.
// Optional request counters (readCount/writeCount) are built when MEMORY_BUS_BRAM_STATS_EN is defined.
module memory_bus_bram_slave #(
    parameter int                     DATA_WIDTH         = 24,
    parameter int                     ADDRESS_WIDTH      = 32,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS     = '0,
    parameter int unsigned            DEPTH_WORDS        = 4096,
    parameter int                     BRAM_ADDRESS_WIDTH = 12,
    parameter int                     READ_LATENCY       = 1,
    parameter int                     RESPONSE_DEPTH     = 4,
    parameter int                     ID_WIDTH           = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    memory_bus_bram_slave_if.slave        bus,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bramAddress,
    output logic [DATA_WIDTH-1:0]         bramWriteData,
    output logic                          bramWriteEnable,
    input  logic [DATA_WIDTH-1:0]         bramReadData
`ifdef MEMORY_BUS_BRAM_STATS_EN
    ,
    output logic [31:0]                   readCount,
    output logic [31:0]                   writeCount
`endif
);
    localparam int PTR_W = $clog2(RESPONSE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OCC_W = $clog2(RESPONSE_DEPTH + READ_LATENCY + 1) + 1;

    logic [ADDRESS_WIDTH-1:0] offset;
    logic                     in_range;
    logic [OCC_W-1:0]         inflight;
    logic [OCC_W-1:0]         occupancy;
    logic                     credit_ok;
    logic                     accept_read;
    logic                     accept_write;
    logic                     push;
    logic                     pop;

    logic [READ_LATENCY:0]    tag_valid;
    logic [ID_WIDTH-1:0]      tag_id [READ_LATENCY+1];

    logic [ID_WIDTH-1:0]      fifo_id   [RESPONSE_DEPTH];
    logic [DATA_WIDTH-1:0]    fifo_data [RESPONSE_DEPTH];
    logic [PTR_W-1:0]         rd_ptr;
    logic [PTR_W-1:0]         wr_ptr;
    logic [CNT_W-1:0]         fifo_count;

    // Unsigned subtraction makes addresses below the base wrap high and fall out of range.
    assign offset   = bus.msAddress - BASE_ADDRESS;
    assign in_range = offset < ADDRESS_WIDTH'(DEPTH_WORDS);

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= READ_LATENCY; i++) begin
            inflight = inflight + OCC_W'(tag_valid[i]);
        end
    end

    // A pop this cycle frees its slot for a read accepted in the same cycle.
    assign pop       = (fifo_count != '0) && bus.smTaken;
    assign occupancy = OCC_W'(fifo_count) + inflight - OCC_W'(pop);
    assign credit_ok = occupancy < OCC_W'(RESPONSE_DEPTH);

    assign bus.msTaken  = reset && bus.msValid && in_range && (bus.msWrite || credit_ok);
    assign accept_read  = bus.msTaken && !bus.msWrite;
    assign accept_write = bus.msTaken && bus.msWrite;
    assign push         = tag_valid[READ_LATENCY];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bramAddress     <= '0;
            bramWriteData   <= '0;
            bramWriteEnable <= 1'b0;
        end else begin
            bramWriteEnable <= accept_write;
            if (bus.msTaken) begin
                bramAddress <= offset[BRAM_ADDRESS_WIDTH-1:0];
            end
            if (accept_write) begin
                bramWriteData <= bus.msData;
            end
        end
    end

    // Tag pipe: stage READ_LATENCY lines up with bramReadData for the same read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_valid <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) begin
                tag_id[i] <= '0;
            end
        end else begin
            tag_valid <= {tag_valid[READ_LATENCY-1:0], accept_read};
            tag_id[0] <= bus.msID;
            for (int i = 1; i <= READ_LATENCY; i++) begin
                tag_id[i] <= tag_id[i-1];
            end
        end
    end

    // NOTE: FIFO storage is not reset; the count and output gating make stale entries invisible.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_id[wr_ptr]   <= tag_id[READ_LATENCY];
            fifo_data[wr_ptr] <= bramReadData;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.smValid = fifo_count != '0;
    assign bus.smID    = bus.smValid ? fifo_id[rd_ptr]   : '0;
    assign bus.smData  = bus.smValid ? fifo_data[rd_ptr] : '0;

`ifdef MEMORY_BUS_BRAM_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readCount  <= '0;
            writeCount <= '0;
        end else begin
            if (accept_read) begin
                readCount <= readCount + 32'd1;
            end
            if (accept_write) begin
                writeCount <= writeCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_bus_bram_slave.sv
// Directed bench for memory_bus_bram_slave: behavioural 1-cycle BRAM, base 0x1000, 4-entry response FIFO.
module tb_memory_bus_bram_slave;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clock;
    logic        reset;
    logic [11:0] bramAddress;
    logic [23:0] bramWriteData;
    logic        bramWriteEnable;
    logic [23:0] bramReadData;
`ifdef MEMORY_BUS_BRAM_STATS_EN
    logic [31:0] readCount;
    logic [31:0] writeCount;
`endif

    int checks;
    int passes;

    memory_bus_bram_slave_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(24), .ID_WIDTH(4)) bus ();

    memory_bus_bram_slave #(
        .DATA_WIDTH(24), .ADDRESS_WIDTH(32), .BASE_ADDRESS(BASE), .DEPTH_WORDS(4096),
        .BRAM_ADDRESS_WIDTH(12), .READ_LATENCY(1), .RESPONSE_DEPTH(4), .ID_WIDTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .bramAddress(bramAddress),
        .bramWriteData(bramWriteData),
        .bramWriteEnable(bramWriteEnable),
        .bramReadData(bramReadData)
`ifdef MEMORY_BUS_BRAM_STATS_EN
        ,
        .readCount(readCount),
        .writeCount(writeCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BRAM model: contents reload to pattern 0xC00000|addr on reset, one-cycle registered read.
    logic [23:0] bram [4096];
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4096; i++) bram[i] <= 24'hC00000 | 24'(i);
            bramReadData <= '0;
        end else begin
            if (bramWriteEnable) bram[bramAddress] <= bramWriteData;
            bramReadData <= bram[bramAddress];
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic valid, input logic write, input logic [31:0] addr,
                         input logic [3:0] id, input logic [23:0] data);
        bus.msValid   = valid;
        bus.msWrite   = write;
        bus.msAddress = addr;
        bus.msID      = id;
        bus.msData    = data;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        drive(1'b1, 1'b0, BASE + 32'd3, 4'd1, 24'h0);
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.msTaken !== 1'b0) $display("FAIL rst_taken: got %b want 0", bus.msTaken); else passes++;
        checks++; if (bus.smValid !== 1'b0) $display("FAIL rst_smvalid: got %b want 0", bus.smValid); else passes++;
        checks++; if (bus.smID !== 4'h0) $display("FAIL rst_smid: got %h want 0", bus.smID); else passes++;
        checks++; if (bus.smData !== 24'h0) $display("FAIL rst_smdata: got %h want 0", bus.smData); else passes++;
        checks++; if (bramAddress !== 12'h0) $display("FAIL rst_addr: got %h want 0", bramAddress); else passes++;
        checks++; if (bramWriteData !== 24'h0) $display("FAIL rst_wdata: got %h want 0", bramWriteData); else passes++;
        checks++; if (bramWriteEnable !== 1'b0) $display("FAIL rst_we: got %b want 0", bramWriteEnable); else passes++;
        bus.msValid = 1'b0;
        reset = 1'b1;
        step();
        checks++; if (bus.smValid !== 1'b0) $display("FAIL rst_release_smvalid: got %b want 0", bus.smValid); else passes++;
    endtask

    task automatic test_write_read();
        drive(1'b1, 1'b1, BASE + 32'd5, 4'd1, 24'hABCDEF);
        #1;
        checks++; if (bus.msTaken !== 1'b1) $display("FAIL wr_taken: got %b want 1", bus.msTaken); else passes++;
        step();
        checks++; if (bramWriteEnable !== 1'b1) $display("FAIL wr_we: got %b want 1", bramWriteEnable); else passes++;
        checks++; if (bramAddress !== 12'd5) $display("FAIL wr_addr: got %h want 005", bramAddress); else passes++;
        checks++; if (bramWriteData !== 24'hABCDEF) $display("FAIL wr_data: got %h want abcdef", bramWriteData); else passes++;
        drive(1'b1, 1'b0, BASE + 32'd5, 4'd2, 24'h0);
        #1;
        checks++; if (bus.msTaken !== 1'b1) $display("FAIL rd_taken: got %b want 1", bus.msTaken); else passes++;
        step();
        bus.msValid = 1'b0;
        checks++; if (bramWriteEnable !== 1'b0) $display("FAIL we_pulse: got %b want 0", bramWriteEnable); else passes++;
        checks++; if (bramAddress !== 12'd5) $display("FAIL rd_addr: got %h want 005", bramAddress); else passes++;
        checks++; if (bus.smValid !== 1'b0) $display("FAIL rd_early1: got %b want 0", bus.smValid); else passes++;
        step();
        checks++; if (bus.smValid !== 1'b0) $display("FAIL rd_early2: got %b want 0", bus.smValid); else passes++;
        step();
        checks++; if (bus.smValid !== 1'b1) $display("FAIL rd_valid: got %b want 1", bus.smValid); else passes++;
        checks++; if (bus.smID !== 4'd2) $display("FAIL rd_id: got %h want 2", bus.smID); else passes++;
        checks++; if (bus.smData !== 24'hABCDEF) $display("FAIL rd_data: got %h want abcdef", bus.smData); else passes++;
        bus.smTaken = 1'b1;
        step();
        bus.smTaken = 1'b0;
        checks++; if (bus.smValid !== 1'b0) $display("FAIL rd_popped: got %b want 0", bus.smValid); else passes++;
    endtask

    task automatic test_out_of_range();
        bit activity = 1'b0;
        drive(1'b1, 1'b0, BASE + 32'd4096, 4'd3, 24'h0);
        for (int c = 0; c < 20; c++) begin
            #1;
            checks++; if (bus.msTaken !== 1'b0) $display("FAIL oor_high_taken c%0d: got %b want 0", c, bus.msTaken); else passes++;
            if (bramWriteEnable || bus.smValid || bramAddress != 12'd5) activity = 1'b1;
            step();
        end
        drive(1'b1, 1'b1, BASE - 32'd1, 4'd3, 24'h123456);
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (bus.msTaken !== 1'b0) $display("FAIL oor_low_taken c%0d: got %b want 0", c, bus.msTaken); else passes++;
            step();
            if (bramWriteEnable || bus.smValid || bramAddress != 12'd5) activity = 1'b1;
        end
        bus.msValid = 1'b0;
        checks++; if (activity !== 1'b0) $display("FAIL oor_activity: got %b want 0", activity); else passes++;
    endtask

    task automatic test_back_to_back();
        int req = 0;
        int resp = 0;
        logic [9:0] mask = '0;
        bus.smTaken = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(req < 6, 1'b0, BASE + 32'h10 + 32'(req), 4'(req), 24'h0);
            #1;
            if (bus.msTaken) begin
                mask[c] = 1'b1;
                req++;
            end
            step();
        end
        checks++; if (req !== 4) $display("FAIL b2b_stalled_accepts: got %0d want 4", req); else passes++;
        checks++; if (mask !== 10'b00_0000_1111) $display("FAIL b2b_accept_cycles: got %b want 0000001111", mask); else passes++;
        for (int c = 0; c < 40 && resp < 6; c++) begin
            bus.smTaken = 1'b1;
            drive(req < 6, 1'b0, BASE + 32'h10 + 32'(req), 4'(req), 24'h0);
            #1;
            if (bus.smValid) begin
                checks++; if (bus.smID !== 4'(resp)) $display("FAIL b2b_id%0d: got %h want %h", resp, bus.smID, 4'(resp)); else passes++;
                checks++; if (bus.smData !== 24'hC00010 + 24'(resp)) $display("FAIL b2b_data%0d: got %h want %h", resp, bus.smData, 24'hC00010 + 24'(resp)); else passes++;
                resp++;
            end
            if (bus.msTaken) req++;
            step();
        end
        bus.msValid = 1'b0;
        bus.smTaken = 1'b0;
        checks++; if (resp !== 6) $display("FAIL b2b_responses: got %0d want 6", resp); else passes++;
        checks++; if (req !== 6) $display("FAIL b2b_total_accepts: got %0d want 6", req); else passes++;
    endtask

    task automatic test_full_pop_accept();
        int n = 0;
        bus.smTaken = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, BASE + 32'h20 + 32'(i), 4'(8 + i), 24'h0);
            #1;
            checks++; if (bus.msTaken !== 1'b1) $display("FAIL fill_taken%0d: got %b want 1", i, bus.msTaken); else passes++;
            step();
        end
        bus.msValid = 1'b0;
        repeat (4) step();
        drive(1'b1, 1'b0, BASE + 32'h24, 4'd12, 24'h0);
        #1;
        checks++; if (bus.msTaken !== 1'b0) $display("FAIL full_blocks: got %b want 0", bus.msTaken); else passes++;
        step();
        bus.smTaken = 1'b1;
        #1;
        checks++; if (bus.msTaken !== 1'b1) $display("FAIL pop_credit_accept: got %b want 1", bus.msTaken); else passes++;
        checks++; if (bus.smID !== 4'd8) $display("FAIL pop_head_id: got %h want 8", bus.smID); else passes++;
        step();
        bus.msValid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.smValid && n < 4) begin
                checks++; if (bus.smID !== 4'(9 + n)) $display("FAIL full_drain_id%0d: got %h want %h", n, bus.smID, 4'(9 + n)); else passes++;
                checks++; if (bus.smData !== 24'hC00021 + 24'(n)) $display("FAIL full_drain_data%0d: got %h want %h", n, bus.smData, 24'hC00021 + 24'(n)); else passes++;
                n++;
            end
            step();
        end
        bus.smTaken = 1'b0;
        checks++; if (n !== 4) $display("FAIL full_drain_count: got %0d want 4", n); else passes++;
    endtask

    task automatic test_reset_mid();
        bit stale = 1'b0;
        bus.smTaken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, BASE + 32'h30 + 32'(i), 4'(1 + i), 24'h0);
            #1;
            checks++; if (bus.msTaken !== 1'b1) $display("FAIL mid_taken%0d: got %b want 1", i, bus.msTaken); else passes++;
            step();
        end
        drive(1'b1, 1'b0, BASE + 32'h33, 4'd6, 24'h0);
        checks++; if (bus.smValid !== 1'b1 || bus.smID !== 4'd1) $display("FAIL mid_pre_head: got v%b id%h want v1 id1", bus.smValid, bus.smID); else passes++;
        reset = 1'b0;
        #1;
        checks++; if (bus.smValid !== 1'b0) $display("FAIL mid_smvalid: got %b want 0", bus.smValid); else passes++;
        checks++; if (bus.smData !== 24'h0) $display("FAIL mid_smdata: got %h want 0", bus.smData); else passes++;
        checks++; if (bus.msTaken !== 1'b0) $display("FAIL mid_taken_low: got %b want 0", bus.msTaken); else passes++;
        step();
        step();
        bus.msValid = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bus.smValid) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) $display("FAIL mid_stale_response: got %b want 0", stale); else passes++;
        drive(1'b1, 1'b0, BASE + 32'h33, 4'd7, 24'h0);
        #1;
        checks++; if (bus.msTaken !== 1'b1) $display("FAIL mid_new_taken: got %b want 1", bus.msTaken); else passes++;
        step();
        bus.msValid = 1'b0;
        step();
        step();
        checks++; if (bus.smValid !== 1'b1 || bus.smID !== 4'd7 || bus.smData !== 24'hC00033)
            $display("FAIL mid_new_resp: got v%b id%h d%h want v1 id7 dc00033", bus.smValid, bus.smID, bus.smData);
        else passes++;
        bus.smTaken = 1'b1;
        step();
        bus.smTaken = 1'b0;
    endtask

    task automatic test_stats();
        logic        req_wr   [10];
        logic [31:0] req_addr [10];
        logic [23:0] req_data [10];
        logic [23:0] exp_data [7];
        int i = 0;
        int r = 0;
        req_wr   = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        req_addr = '{32'h40, 32'h41, 32'h42, 32'h40, 32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h46};
        req_data = '{24'h111111, 24'h222222, 24'h333333, 0, 0, 0, 0, 0, 0, 0};
        exp_data = '{24'h111111, 24'h222222, 24'h333333, 24'hC00043, 24'hC00044, 24'hC00045, 24'hC00046};
        reset = 1'b0;
        step();
        reset = 1'b1;
        bus.smTaken = 1'b1;
        for (int c = 0; c < 60 && r < 7; c++) begin
            drive(i < 10, (i < 10) ? req_wr[i % 10] : 1'b0, BASE + req_addr[i % 10], 4'(i % 10), req_data[i % 10]);
            #1;
            if (bus.smValid) begin
                checks++; if (bus.smData !== exp_data[r % 7]) $display("FAIL stats_data%0d: got %h want %h", r, bus.smData, exp_data[r % 7]); else passes++;
                r++;
            end
            if (bus.msTaken) i++;
            step();
        end
        bus.msValid = 1'b0;
        bus.smTaken = 1'b0;
        checks++; if (i !== 10) $display("FAIL stats_accepts: got %0d want 10", i); else passes++;
        checks++; if (r !== 7) $display("FAIL stats_responses: got %0d want 7", r); else passes++;
`ifdef MEMORY_BUS_BRAM_STATS_EN
        checks++; if (writeCount !== 32'd3) $display("FAIL stats_write_count: got %0d want 3", writeCount); else passes++;
        checks++; if (readCount !== 32'd7) $display("FAIL stats_read_count: got %0d want 7", readCount); else passes++;
`endif
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset = 1'b1;
        bus.smTaken = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 4'h0, 24'h0);
        test_reset();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_full_pop_accept();
        test_reset_mid();
        test_stats();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
